// File: rtl/conway_engine_if.sv
// Row-load handshake between a grid loader (master) and conway_engine (slave).
// One row of WIDTH cells moves on every cycle where valid and ready are both high.
interface conway_engine_if #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32
);
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic             valid;
  logic             ready;
  logic [ROW_W-1:0] row;
  logic [WIDTH-1:0] data;

  modport master (output valid, row, data, input ready);
  modport slave  (input valid, row, data, output ready);
endinterface

// File: rtl/conway_engine.sv
// Game-of-Life engine: WIDTH x HEIGHT cell array, one generation per committed step,
// runtime birth/survive rules, dead or toroidal border, row loading and settle detection.
module conway_engine #(
  parameter int WIDTH     = 32,
  parameter int HEIGHT    = 32,
  parameter int WRAP      = 0,
  parameter int GEN_W     = 16,
  parameter int AUTO_HALT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      step_en,
  input  logic                      step_one,
  input  logic [8:0]                birth_mask,
  input  logic [8:0]                survive_mask,
  conway_engine_if.slave            load,
  output logic [WIDTH*HEIGHT-1:0]   grid_pack,
  output logic [GEN_W-1:0]          generation,
  output logic                      gen_done,
  output logic                      stable,
  output logic                      extinct,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, SINGLE, RUN} state_t;
  typedef logic [HEIGHT-1:0][WIDTH-1:0] grid_t;

  localparam logic WRAP_ON = (WRAP != 0);
  localparam logic HALT_ON = (AUTO_HALT != 0);
  localparam int   R0      = HEIGHT / 2;
  localparam int   C0      = WIDTH / 2;

  function automatic grid_t seed_grid();
    grid_t g;
    g = '0;
    g[R0+1][C0]   = 1'b1;
    g[R0][C0+1]   = 1'b1;
    g[R0-1][C0-1] = 1'b1;
    g[R0-1][C0]   = 1'b1;
    g[R0-1][C0+1] = 1'b1;
    return g;
  endfunction

  localparam grid_t SEED = seed_grid();

  // Border columns take the opposite edge when wrapping, otherwise read as dead.
  function automatic logic [WIDTH+1:0] ext_row(input logic [WIDTH-1:0] row);
    return {WRAP_ON & row[0], row, WRAP_ON & row[WIDTH-1]};
  endfunction

  state_t state, state_nx;
  grid_t  cells, cells_nx;
  logic   commit;
  logic   settled;
  logic   load_hit;
  logic [HEIGHT+1:0][WIDTH+1:0] pad;

  // Grid framed by a one-cell halo so every cell sees the same 3x3 window.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pad = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      pad[r+1] = ext_row(cells[r]);
    end
    if (WRAP_ON) begin
      pad[0]        = ext_row(cells[HEIGHT-1]);
      pad[HEIGHT+1] = ext_row(cells[0]);
    end
  end

  always_comb begin
    logic [3:0] n;
    n        = '0;
    cells_nx = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        n = '0;
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            if (dr != 1 || dc != 1) n = n + {3'b000, pad[r+dr][c+dc]};
          end
        end
        cells_nx[r][c] = cells[r][c] ? survive_mask[n] : birth_mask[n];
      end
    end
  end

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (run)           state_nx = RUN;
        else if (step_one) state_nx = SINGLE;
      end
      SINGLE: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      RUN: begin
        // A settled grid stops the run before another step can be taken.
        if (HALT_ON && settled) begin
          state_nx = IDLE;
        end else begin
          commit = step_en;
          if (!run) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign load.ready = (state == IDLE);
  assign load_hit   = (state == IDLE) && load.valid && (int'(load.row) < HEIGHT);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state      <= IDLE;
      // NOTE: the grid is live state with a defined power-up pattern, so it is reset like any other register.
      cells      <= SEED;
      generation <= '0;
      gen_done   <= 1'b0;
      stable     <= 1'b0;
      extinct    <= 1'b0;
      settled    <= 1'b0;
    end else begin
      state    <= state_nx;
      gen_done <= commit;
      settled  <= commit && ((cells_nx == cells) || (cells_nx == '0));
      if (commit) begin
        cells      <= cells_nx;
        generation <= generation + GEN_W'(1);
        stable     <= (cells_nx == cells);
        extinct    <= (cells_nx == '0);
      end else if (load_hit) begin
        cells[load.row] <= load.data;
        generation      <= '0;
        stable          <= 1'b0;
        extinct         <= 1'b0;
      end
    end
  end

  assign grid_pack = cells;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_conway_engine.sv
// Self-checking bench for conway_engine: three instances (32x32 dead border, 32x32 torus,
// 8x6 torus with a 4-bit counter) checked against a cell-by-cell Life model kept here.
module tb_conway_engine;

  localparam int ND = 3;
  typedef logic [1023:0] grid_t;
  typedef struct {
    grid_t       grid;
    logic [15:0] gen;
    logic        done, stable, extinct, busy, ready;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset   [ND];
  logic        run     [ND];
  logic        step_en [ND];
  logic        step_one[ND];
  logic [8:0]  bmask   [ND];
  logic [8:0]  smask   [ND];
  logic        lv      [ND];
  logic [4:0]  lrow    [ND];
  logic [31:0] ldata   [ND];

  logic [1023:0] g0, g1;
  logic [47:0]   g2;
  logic [15:0]   gen0, gen1;
  logic [3:0]    gen2;
  logic gd0, gd1, gd2, st0, st1, st2, ex0, ex1, ex2, bz0, bz1, bz2;

  conway_engine_if #(.WIDTH(32), .HEIGHT(32)) lif0 ();
  conway_engine_if #(.WIDTH(32), .HEIGHT(32)) lif1 ();
  conway_engine_if #(.WIDTH(8),  .HEIGHT(6))  lif2 ();

  assign lif0.valid = lv[0];  assign lif0.row = lrow[0];       assign lif0.data = ldata[0];
  assign lif1.valid = lv[1];  assign lif1.row = lrow[1];       assign lif1.data = ldata[1];
  assign lif2.valid = lv[2];  assign lif2.row = lrow[2][2:0];  assign lif2.data = ldata[2][7:0];

  conway_engine #(.WIDTH(32), .HEIGHT(32), .WRAP(0), .GEN_W(16), .AUTO_HALT(1)) dut0 (
    .clk(clk), .reset(reset[0]), .run(run[0]), .step_en(step_en[0]), .step_one(step_one[0]),
    .birth_mask(bmask[0]), .survive_mask(smask[0]), .load(lif0), .grid_pack(g0),
    .generation(gen0), .gen_done(gd0), .stable(st0), .extinct(ex0), .busy(bz0));

  conway_engine #(.WIDTH(32), .HEIGHT(32), .WRAP(1), .GEN_W(16), .AUTO_HALT(1)) dut1 (
    .clk(clk), .reset(reset[1]), .run(run[1]), .step_en(step_en[1]), .step_one(step_one[1]),
    .birth_mask(bmask[1]), .survive_mask(smask[1]), .load(lif1), .grid_pack(g1),
    .generation(gen1), .gen_done(gd1), .stable(st1), .extinct(ex1), .busy(bz1));

  conway_engine #(.WIDTH(8), .HEIGHT(6), .WRAP(1), .GEN_W(4), .AUTO_HALT(1)) dut2 (
    .clk(clk), .reset(reset[2]), .run(run[2]), .step_en(step_en[2]), .step_one(step_one[2]),
    .birth_mask(bmask[2]), .survive_mask(smask[2]), .load(lif2), .grid_pack(g2),
    .generation(gen2), .gen_done(gd2), .stable(st2), .extinct(ex2), .busy(bz2));

  int checks = 0;
  int errors = 0;
  int done_cnt [ND] = '{0, 0, 0};

  grid_t exp_grid[ND];
  int    exp_gen [ND];
  logic  exp_st  [ND];
  logic  exp_ex  [ND];

  always @(negedge clk) begin
    if (gd0) done_cnt[0]++;
    if (gd1) done_cnt[1]++;
    if (gd2) done_cnt[2]++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int hgt(int d); return (d == 2) ? 6 : 32; endfunction
  function automatic int wid(int d); return (d == 2) ? 8 : 32; endfunction
  function automatic bit wrp(int d); return d != 0; endfunction
  function automatic int gmod(int d); return (d == 2) ? 16 : 65536; endfunction

  function automatic obs_t sample(int d);
    obs_t o;
    o.grid = '0;
    case (d)
      0: begin o.grid = g0; o.gen = gen0; o.done = gd0; o.stable = st0; o.extinct = ex0;
               o.busy = bz0; o.ready = lif0.ready; end
      1: begin o.grid = g1; o.gen = gen1; o.done = gd1; o.stable = st1; o.extinct = ex1;
               o.busy = bz1; o.ready = lif1.ready; end
      default: begin o.grid[47:0] = g2; o.gen = {12'b0, gen2}; o.done = gd2; o.stable = st2;
               o.extinct = ex2; o.busy = bz2; o.ready = lif2.ready; end
    endcase
    return o;
  endfunction

  function automatic grid_t seed_of(int d);
    int h = hgt(d);
    int w = wid(d);
    int r = h / 2;
    int c = w / 2;
    grid_t g = '0;
    g[(r+1)*w + c]   = 1'b1;
    g[r*w + c + 1]   = 1'b1;
    g[(r-1)*w + c-1] = 1'b1;
    g[(r-1)*w + c]   = 1'b1;
    g[(r-1)*w + c+1] = 1'b1;
    return g;
  endfunction

  // Life rule straight from its definition: count the eight neighbours, apply the masks.
  function automatic grid_t model_next(grid_t g, int d, logic [8:0] b, logic [8:0] s);
    int h = hgt(d);
    int w = wid(d);
    grid_t nx = '0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (wrp(d)) begin
              rr = (rr + h) % h;
              cc = (cc + w) % w;
            end else if (rr < 0 || rr >= h || cc < 0 || cc >= w) begin
              continue;
            end
            n += int'(g[rr*w + cc]);
          end
        end
        nx[r*w + c] = g[r*w + c] ? s[n] : b[n];
      end
    end
    return nx;
  endfunction

  function automatic logic [63:0] row_of(grid_t g, int r, int w);
    logic [63:0] v = '0;
    for (int c = 0; c < w; c++) v[c] = g[r*w + c];
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic grid_check(input string tag, input int d, input grid_t exp);
    obs_t o = sample(d);
    int   w = wid(d);
    int   bad = 0;
    for (int r = hgt(d) - 1; r >= 0; r--)
      if (row_of(o.grid, r, w) !== row_of(exp, r, w)) bad = r;
    check($sformatf("%s.row%0d", tag, bad), row_of(o.grid, bad, w), row_of(exp, bad, w));
  endtask

  task automatic expect_all(input string tag, input int d);
    obs_t o = sample(d);
    grid_check({tag, ".grid"}, d, exp_grid[d]);
    check({tag, ".gen"}, o.gen, exp_gen[d]);
    check({tag, ".stable"}, o.stable, exp_st[d]);
    check({tag, ".extinct"}, o.extinct, exp_ex[d]);
  endtask

  task automatic model_commit(input int d);
    grid_t nx = model_next(exp_grid[d], d, bmask[d], smask[d]);
    exp_st[d]   = (nx == exp_grid[d]);
    exp_ex[d]   = (nx == '0);
    exp_grid[d] = nx;
    exp_gen[d]  = (exp_gen[d] + 1) % gmod(d);
  endtask

  task automatic do_reset(input int d, input string tag);
    obs_t o;
    reset[d] = 1'b1;
    tick();
    reset[d]    = 1'b0;
    exp_grid[d] = seed_of(d);
    exp_gen[d]  = 0;
    exp_st[d]   = 1'b0;
    exp_ex[d]   = 1'b0;
    o = sample(d);
    expect_all(tag, d);
    check({tag, ".done"}, o.done, 1'b0);
    check({tag, ".busy"}, o.busy, 1'b0);
    check({tag, ".ready"}, o.ready, 1'b1);
  endtask

  task automatic load(input int d, input int row, input logic [31:0] data);
    lv[d]    = 1'b1;
    lrow[d]  = 5'(row);
    ldata[d] = data;
    tick();
    lv[d] = 1'b0;
    if (row < hgt(d)) begin
      for (int c = 0; c < wid(d); c++) exp_grid[d][row*wid(d) + c] = data[c];
      exp_gen[d] = 0;
      exp_st[d]  = 1'b0;
      exp_ex[d]  = 1'b0;
    end
  endtask

  task automatic step_single(input int d, input string tag);
    obs_t o;
    bit   seen = 1'b0;
    step_one[d] = 1'b1;
    tick();
    step_one[d] = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      o = sample(d);
      seen = o.done;
    end
    check({tag, ".gen_done"}, seen, 1'b1);
    model_commit(d);
    expect_all(tag, d);
    check({tag, ".busy"}, o.busy, 1'b0);
  endtask

  task automatic run_gens(input int d, input int target, input int budget, input bit rnd,
                          input bit try_load, input string tag, output int got);
    obs_t o;
    bit   ended = 1'b0;
    got    = 0;
    run[d] = 1'b1;
    for (int cyc = 0; cyc < budget && !ended; cyc++) begin
      step_en[d] = rnd ? ($urandom_range(3) != 0) : 1'b1;
      if (try_load) begin
        lv[d]    = (cyc >= 3 && cyc < 6);
        lrow[d]  = 5'd0;
        ldata[d] = '1;
      end
      tick();
      o = sample(d);
      if (try_load && cyc >= 3 && cyc < 6) check({tag, ".ready_in_run"}, o.ready, 1'b0);
      if (o.done) begin
        model_commit(d);
        got++;
        grid_check($sformatf("%s.g%0d", tag, got), d, exp_grid[d]);
      end
      if (got == target || (cyc > 0 && !o.busy)) ended = 1'b1;
    end
    run[d]     = 1'b0;
    step_en[d] = 1'b0;
    lv[d]      = 1'b0;
    check({tag, ".ended_in_budget"}, ended, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t  o;
    grid_t k;
    int    got;
    int    base;

    for (int d = 0; d < ND; d++) begin
      reset[d] = 1'b1; run[d] = 1'b0; step_en[d] = 1'b0; step_one[d] = 1'b0;
      bmask[d] = 9'h008; smask[d] = 9'h00C;
      lv[d] = 1'b0; lrow[d] = '0; ldata[d] = '0;
    end

    // Reset pattern on the 32x32 dead-border instance, against the literal glider bits.
    do_reset(0, "reset0");
    k = '0;
    k[17*32+16] = 1'b1; k[16*32+17] = 1'b1;
    k[15*32+15] = 1'b1; k[15*32+16] = 1'b1; k[15*32+17] = 1'b1;
    grid_check("reset0.literal", 0, k);

    // Blinker: two single steps flip it vertical then back.
    load(0, 15, 32'h0);
    load(0, 16, 32'h0003_8000);
    load(0, 17, 32'h0);
    base = done_cnt[0];
    step_single(0, "blink1");
    k = '0;
    k[15*32+16] = 1'b1; k[16*32+16] = 1'b1; k[17*32+16] = 1'b1;
    grid_check("blink.vertical", 0, k);
    step_single(0, "blink2");
    k = '0;
    k[16*32+15] = 1'b1; k[16*32+16] = 1'b1; k[16*32+17] = 1'b1;
    grid_check("blink.horizontal", 0, k);
    tick();
    o = sample(0);
    check("blink.generation", o.gen, 2);
    check("blink.stable", o.stable, 1'b0);
    check("blink.pulses", done_cnt[0] - base, 2);

    // Seeds rule on a domino: four births, both originals die.
    bmask[0] = 9'h004; smask[0] = 9'h000;
    load(0, 15, 32'h0);
    load(0, 16, 32'h0003_0000);
    load(0, 17, 32'h0);
    step_single(0, "seeds");
    k = '0;
    k[15*32+16] = 1'b1; k[15*32+17] = 1'b1; k[17*32+16] = 1'b1; k[17*32+17] = 1'b1;
    grid_check("seeds.literal", 0, k);
    bmask[0] = 9'h008; smask[0] = 9'h00C;

    // Lone cell in RUN dies in one generation and the run halts on the following edge.
    load(0, 15, 32'h0);
    load(0, 16, 32'h0000_0020);
    load(0, 17, 32'h0);
    run[0] = 1'b1; step_en[0] = 1'b1;
    tick();
    o = sample(0);
    check("lone.busy_enter", o.busy, 1'b1);
    check("lone.no_done_yet", o.done, 1'b0);
    tick();
    model_commit(0);
    o = sample(0);
    check("lone.gen_done", o.done, 1'b1);
    check("lone.busy_commit", o.busy, 1'b1);
    expect_all("lone", 0);
    tick();
    o = sample(0);
    check("lone.busy_drop", o.busy, 1'b0);
    check("lone.no_extra_done", o.done, 1'b0);
    check("lone.gen_hold", o.gen, 1);
    run[0] = 1'b0; step_en[0] = 1'b0;
    tick();

    // Reset asserted in the middle of a run restores the glider immediately.
    do_reset(0, "pre_midrun");
    run[0] = 1'b1; step_en[0] = 1'b1;
    repeat (6) tick();
    reset[0] = 1'b1;
    tick();
    exp_grid[0] = seed_of(0); exp_gen[0] = 0; exp_st[0] = 1'b0; exp_ex[0] = 1'b0;
    o = sample(0);
    expect_all("midrun_reset", 0);
    check("midrun_reset.busy", o.busy, 1'b0);
    check("midrun_reset.done", o.done, 1'b0);
    reset[0] = 1'b0; run[0] = 1'b0; step_en[0] = 1'b0;
    tick();

    // Glider against the dead border settles and auto-halts; loads during RUN are refused.
    do_reset(0, "glider0");
    run_gens(0, -1, 1500, 1'b0, 1'b1, "glider0", got);
    o = sample(0);
    check("glider0.busy_after_halt", o.busy, 1'b0);
    check("glider0.stable_flag", o.stable, 1'b1);
    check("glider0.live_cells", $countones(o.grid), 4);
    expect_all("glider0.final", 0);
    tick();
    o = sample(0);
    check("glider0.idle_hold", o.busy, 1'b0);
    check("glider0.gen_hold", o.gen, exp_gen[0]);

    // Random rules and grids, single-stepped.
    for (int it = 0; it < 6; it++) begin
      bmask[0] = (it % 2 == 0) ? 9'h008 : 9'($urandom);
      smask[0] = (it % 2 == 0) ? 9'h00C : 9'($urandom);
      for (int r = 0; r < 32; r++) load(0, r, $urandom & $urandom);
      for (int s = 0; s < 3; s++) step_single(0, $sformatf("rand0.%0d.%0d", it, s));
    end
    bmask[0] = 9'h008; smask[0] = 9'h00C;

    // Torus: the glider comes home after 128 generations, with gaps in step_en.
    do_reset(1, "reset1");
    run_gens(1, 128, 1000, 1'b1, 1'b0, "glider1", got);
    check("glider1.count", got, 128);
    tick();
    o = sample(1);
    grid_check("glider1.home", 1, seed_of(1));
    check("glider1.generation", o.gen, 128);
    check("glider1.busy", o.busy, 1'b0);
    check("glider1.stable", o.stable, 1'b0);

    // Small torus: random rules, counter wrap at 16, out-of-range rows ignored.
    do_reset(2, "reset2");
    for (int r = 0; r < 6; r++) load(2, r, $urandom);
    bmask[2] = 9'h008 | 9'($urandom_range(511) & 9'h0F0);
    smask[2] = 9'h00C;
    for (int s = 0; s < 20; s++) step_single(2, $sformatf("rand2.%0d", s));
    load(2, 6, 32'hFF);
    load(2, 7, 32'hA5);
    tick();
    expect_all("oob_rows", 2);
    load(2, 2, 32'h5A);
    tick();
    expect_all("row2_load", 2);
    step_single(2, "after_load2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
